conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
- Parametrised streaming 2D convolution engine for the image-processing datapath.
- Accepts one signed pixel per beat in raster order and holds K×K coefficients loaded through a config port.
- Produces the "valid" (no padding) convolution output, (IMG_H-K+1)×(IMG_W-K+1) samples per frame, on a valid/ready stream.
- Uses K-1 line buffers plus a K×K window register, so the input frame is never stored whole.

Parameters:
- DATA_W, 8, signed pixel width
- COEF_W, 8, signed coefficient width
- IMG_W, 8, frame width in pixels (>= K)
- IMG_H, 8, frame height in lines (>= K)
- K, 3, kernel size (K×K), 2..7
- OUT_W, 16, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  clog2(K*K)  coefficient index = ki*K+kj
- cfg_data  in  COEF_W  signed coefficient
- start  in  1  one-cycle pulse that begins a frame
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  DATA_W  signed pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  signed saturated result
- out_last  out  1  marks the final result of the frame
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, state=IDLE. Row/column counters, window and line buffers clear to 0. All coefficients clear to 0.
- Reset mid-frame aborts the frame. Partial results are discarded and no done pulse is generated.

State machine: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE
  - in_ready=0.
  - cfg_we writes coef[cfg_addr]; addresses >= K*K are ignored.
  - start moves to RUN and clears row/col to 0.
- RUN
  - in_ready = !out_valid || out_ready (one-deep output register; back-pressure stalls input).
  - Each accepted pixel shifts into the window and line buffers, then col advances; at IMG_W-1 col wraps to 0 and row increments.
  - After pixel (IMG_H-1, IMG_W-1) is accepted, the state goes to DRAIN and in_ready drops the next cycle.
- DRAIN
  - Wait until the final result is accepted (out_valid && out_ready && out_last).
  - On that acceptance: pulse done for one cycle and return to IDLE.
- cfg_we in RUN or DRAIN is ignored.
- start outside IDLE is ignored.

Computation:
- Accepting pixel (r,c) with r>=K-1 and c>=K-1 completes the window whose top-left corner is (r-K+1, c-K+1).
- Result = sum over ki,kj of coef[ki*K+kj] * px[r-K+1+ki][c-K+1+kj]. This is correlation; the kernel is not flipped.
- Window columns from the previous line never wrap into the current line; the row/col guards above enforce this.
- Accumulator width: DATA_W+COEF_W+clog2(K*K), full precision, signed.
- Post-processing: arithmetic shift right by SHIFT (floor), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: the result is registered. out_valid rises the cycle after the completing pixel is accepted.
- out_data and out_valid hold stable while out_valid && !out_ready.
- out_last=1 only with the result for window (IMG_H-K, IMG_W-K).
- A new frame may start the cycle after done.

Test Plan:
- Identity kernel: coef[K*K/2]=1 (all others 0), defaults, 8×8 ramp px=r*8+c, out_ready=1 -> 36 results. First = 9, last = 54 with out_last=1. Each result appears 1 cycle after pixel (r,c), r,c>=2. done pulses once.
- Saturation: all coefs 127, all pixels 127 -> every result 32767. All pixels -128 -> every result -32768.
- Shift: SHIFT=2, all coefs 1, all pixels -1 -> sum -9 -> out -3 (floor).
- Back-pressure: random out_ready at 30% -> in_ready low whenever out_valid && !out_ready. Output sequence is identical to the identity run with no loss or duplication; out_data stays stable while stalled.
- Config guard: cfg_we with data 5 during RUN -> coefficient unchanged and results match the previous kernel. start pulsed during RUN is ignored.
- Reset mid-frame after 20 pixels -> next cycle all outputs at reset values and coefficients 0. A reloaded identity frame then completes correctly.

Source files
------------

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK "valid" 2D correlation built from K-1 line buffers and a KxK window.
module conv2d_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [$clog2(K*K)-1:0]      cfg_addr,
  input  logic signed [COEF_W-1:0]    cfg_data,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = $clog2(K*K);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int AW = DATA_W + COEF_W + CW;
  localparam int SW = (AW > OUT_W ? AW : OUT_W) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_K = XW'(K - 1);
  localparam logic [YW-1:0] Y_K = YW'(K - 1);
  localparam logic [CW:0] N_COEF = (CW+1)'(K*K);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic signed [COEF_W-1:0] coef [K*K];
  logic signed [DATA_W-1:0] lb [K-1][IMG_W];
  logic signed [DATA_W-1:0] win [K][K];
  logic signed [DATA_W-1:0] vec [K];
  logic signed [DATA_W-1:0] nw [K][K];
  logic signed [AW-1:0] acc, acc_sh;
  logic signed [SW-1:0] shx, maxv, minv;
  logic signed [OUT_W-1:0] sat;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic take, give, at_end, full;

  assign take   = in_valid && in_ready;
  assign give   = out_valid && out_ready;
  assign at_end = row == Y_LAST && col == X_LAST;
  assign full   = row >= Y_K && col >= X_K;

  always_comb begin
    in_ready = state == RUN && (!out_valid || out_ready);
    busy     = state != IDLE;
    state_n  = (state == IDLE && start) ? RUN :
               (state == RUN && take && at_end) ? DRAIN :
               (state == DRAIN && give && out_last) ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // Column entering the window: stored rows oldest-first, live pixel at the bottom.
  always_comb begin
    for (int i = 0; i < K-1; i++) vec[i] = lb[i][col];
    vec[K-1] = in_data;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) nw[i][j] = win[i][j+1];
      nw[i][K-1] = vec[i];
    end
    acc = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc = acc + AW'(coef[i*K+j]) * AW'(nw[i][j]);
    acc_sh = acc >>> SHIFT;
    shx    = {{(SW-AW){acc_sh[AW-1]}}, acc_sh};
    maxv   = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    minv   = ~maxv;
    sat    = shx > maxv ? maxv[OUT_W-1:0] : shx < minv ? minv[OUT_W-1:0] : shx[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < K*K; i++) coef[i] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
      for (int i = 0; i < K-1; i++)
        for (int j = 0; j < IMG_W; j++) lb[i][j] <= '0;
    end else begin
      done <= state == DRAIN && give && out_last;
      if (state == IDLE && cfg_we && {1'b0, cfg_addr} < N_COEF) coef[cfg_addr] <= cfg_data;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (take) begin
        for (int i = 0; i < K-1; i++) lb[i][col] <= vec[i+1];
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) win[i][j] <= nw[i][j];
        col <= col == X_LAST ? '0 : col + 1'b1;
        if (col == X_LAST) row <= row + 1'b1;
      end
      if (take && full) begin
        out_valid <= 1'b1;
        out_data  <= sat;
        out_last  <= at_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed frames checked against a bench-side correlation model and hand values.
module tb_conv2d_stream;
  localparam int K = 3, W = 8, H = 8, NR = (H-K+1)*(W-K+1);

  logic clk = 1'b0;
  logic reset, cfg_we, start, in_valid, out_ready;
  logic [3:0] cfg_addr;
  logic signed [7:0] cfg_data, in_data;
  logic in_ready, out_valid, out_last, busy, done;
  logic signed [15:0] out_data;
  logic in_ready_s, out_valid_s, out_last_s, busy_s, done_s;
  logic signed [15:0] out_data_s;

  int n_assert = 0, n_fail = 0;
  int coef_m [9];
  int first_v, last_v;

  always #5 clk = ~clk;

  conv2d_stream dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  conv2d_stream #(.SHIFT(2)) dut_s (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_last(out_last_s),
    .busy(busy_s), .done(done_s)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int mode, input int r, input int c);
    return mode == 0 ? r*8 + c : mode == 1 ? 127 : mode == 2 ? -128 : -1;
  endfunction

  function automatic int sat16(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  task automatic set_coefs(input int ctr, input int oth);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 4'(i);
      coef_m[i] = i == 4 ? ctr : oth;
      cfg_data = 8'(coef_m[i]);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit bp, input bit inject);
    int exp_q [NR];
    int exp_s [NR];
    int idx = 0, k = 0, ndone = 0, cyc = 0, s;
    bit pend = 0, stall = 0, injd = 0;
    logic signed [15:0] held = '0;
    for (int i = 0; i <= H-K; i++)
      for (int j = 0; j <= W-K; j++) begin
        s = 0;
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++) s += coef_m[a*K+b] * pix(mode, i+a, j+b);
        exp_q[i*(W-K+1)+j] = sat16(s);
        exp_s[i*(W-K+1)+j] = sat16(s >>> 2);
      end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (ndone == 0 && cyc < 3000) begin
      in_valid  = idx < W*H;
      in_data   = 8'(pix(mode, idx / W, idx % W));
      out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (inject && idx == 10 && !injd) begin
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 8'sd5; start = 1'b1; injd = 1;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      #1;
      if (pend) check("latency", out_valid, 1);
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", 32'(out_data), 32'(held));
      end
      if (out_valid && !out_ready) check("in_ready_bp", in_ready, 0);
      if (out_valid && out_ready) begin
        if (k < NR) begin
          check("data", 32'(out_data), exp_q[k]);
          check("data_shift2", 32'(out_data_s), exp_s[k]);
          check("last", out_last, k == NR-1);
          if (k == 0) first_v = out_data;
          last_v = out_data;
        end else check("extra_result", k, NR-1);
        k++;
      end
      pend  = !bp && in_valid && in_ready && idx / W >= K-1 && idx % W >= K-1;
      stall = out_valid && !out_ready;
      held  = out_data;
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      if (done) ndone++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("done_once", ndone, 1);
    check("result_count", k, NR);
    check("pixels_taken", idx, W*H);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    set_coefs(1, 0);
    run_frame(0, 0, 0);
    check("identity_first", first_v, 9);
    check("identity_last", last_v, 54);

    set_coefs(127, 127);
    run_frame(1, 0, 0);
    check("sat_pos", last_v, 32767);
    run_frame(2, 0, 0);
    check("sat_neg", last_v, -32768);

    set_coefs(1, 1);
    run_frame(3, 0, 0);
    check("shift_floor", 32'(out_data_s), -3);

    set_coefs(1, 0);
    run_frame(0, 1, 0);
    check("bp_last", last_v, 54);

    run_frame(0, 0, 1);
    check("guard_last", last_v, 54);

    // Abort a frame after 20 accepted pixels.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 20) begin
      in_valid = 1'b1;
      in_data = 8'(pix(0, n / W, n % W));
      #1;
      if (in_ready) n++;
      @(negedge clk);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", 32'(out_data), 0);
    check("abort_out_last", out_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done, 0);

    for (int i = 0; i < 9; i++) coef_m[i] = 0;
    run_frame(0, 0, 0);
    check("cleared_coefs", last_v, 0);

    set_coefs(1, 0);
    run_frame(0, 0, 0);
    check("reload_first", first_v, 9);
    check("reload_last", last_v, 54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
